triangle_dispatcher: RTL and testbench
======================================

Name: triangle_dispatcher

Overview:
Command-side initiator for the shader, the block that drives v1x..v3z, pixel_color and start, and consumes done.
- A host (HPS/Avalon slave glue) writes triangles word by word into a staging register set.
- Each completed triangle is committed into a small FIFO.
- The block pops triangles one at a time and runs the start/done handshake with the shader until the FIFO drains.
- Status outputs let the host throttle writes and count completed triangles.

Parameters:
DEPTH, 4, FIFO capacity in triangles; power of two, ≥2.
CNT_W, 16, width of completed/culled triangle counters.

Ports:
clk  in  1  system clock (50 MHz domain shared with shader)
reset  in  1  asynchronous, active-low reset
wr_en  in  1  host write strobe, one word per cycle
wr_addr  in  4  word index: 0..8 = v1x,v1y,v1z,v2x,v2y,v2z,v3x,v3y,v3z; 9 = color+commit; 10..15 ignored
wr_data  in  16  word payload
full  out  1  FIFO holds DEPTH triangles
empty  out  1  FIFO holds 0 triangles
busy  out  1  handshake with shader in progress (not IDLE)
overflow  out  1  sticky: commit attempted while full; cleared only by reset
tri_done_cnt  out  CNT_W  triangles completed by shader, wraps
v1x,v1y,v1z,v2x,v2y,v2z,v3x,v3y,v3z  out  16 each  vertex bus to shader
pixel_color  out  16  colour to shader
sh_start  out  1  start to shader
sh_done  in  1  done pulse from shader

Behaviour:
- Reset (reset=0, async): all vertex/colour outputs 0, sh_start 0, staging regs 0, FIFO pointers 0, empty 1, full 0, busy 0, overflow 0, counters 0, FSM IDLE.
- Staging write: on wr_en with addr 0..8, latch word into staging slot addr.
- Commit: addr 9 latches colour and, in the same cycle, pushes staging{9 coords, wr_data} into the FIFO.
- Commit while full: the push is dropped, overflow is set, FIFO is unchanged.
- Staging is not cleared after commit, so the host may rewrite only the changed words.
- FIFO: DEPTH entries, log2(DEPTH)+1-bit pointers; full/empty are registered.
  - Push and pop in the same cycle when full: only the pop occurs this cycle and the push is dropped (overflow set).
  - Push and pop in the same cycle when neither full nor empty: both occur, count unchanged.
- FSM:
  - IDLE: if !empty, pop the head and register it onto v*/pixel_color → LOAD.
  - LOAD: one cycle for shader input setup → START.
  - START: sh_start=1 for exactly one cycle → WAIT.
  - WAIT: sh_start=0, outputs held stable; on sh_done=1, tri_done_cnt+1 → IDLE.
- Latencies:
  - Commit to sh_start high: 3 cycles minimum when IDLE and empty (push, IDLE pop, LOAD, START).
  - Back-to-back triangles: sh_done to next sh_start = 3 cycles.
- Vertex outputs change only on an IDLE pop; they stay stable throughout WAIT.
- sh_done outside WAIT is ignored.
- No timeout: a hung shader leaves busy=1 until reset.
- busy=1 in LOAD, START and WAIT.
- Reset mid-WAIT: FSM returns to IDLE, FIFO is emptied, and the in-flight triangle is lost. The shader shares the reset net, so both sides realign.

Optional Feature:
DEGENERATE_CULL_EN:
- When defined, the IDLE pop checks the head entry; if v1y==v2y==v3y it is discarded.
  - No handshake is run.
  - A CNT_W culled_cnt output increments.
  - The FSM stays in IDLE and pops the next entry on the following cycle.
- When undefined, every entry is dispatched, and the culled_cnt port is absent.

Decomposition:
- Package triangle_pkg holds:
  - tri_t packed struct (9×16 coords + 16 colour = 160 bits);
  - word-index localparams (W_V1X..W_COLOR=9);
  - dispatcher state enum {IDLE, LOAD, START, WAIT}.
- Sub-module tri_fifo: synchronous DEPTH×tri_t FIFO with push/pop/full/empty, async active-low reset.

Test Plan:
- Single triangle: write (10,10,5),(100,20,5),(50,90,5), colour 3 → sh_start pulses once 3 cycles after commit, outputs match; shader model returns done after 200 cycles → tri_done_cnt=1, busy=0, empty=1.
- Burst of DEPTH+1=5 commits while shader stalled → full=1 after 4, fifth commit sets overflow=1; after all dones, tri_done_cnt=4, and the dispatched order matches write order.
- Stability: vary staging writes during WAIT → v1x..pixel_color unchanged until sh_done; a spurious sh_done while IDLE is ignored (count unchanged).
- Simultaneous push/pop with FIFO at 2 entries → count stays 2; with FIFO full, push dropped and overflow set.
- Reset (0) asserted in WAIT with 3 queued → all outputs 0 immediately, empty=1; after release, new commit dispatches normally.
- DEGENERATE_CULL_EN: queue a y=40,40,40 triangle then a valid one → only one sh_start, culled_cnt=1, tri_done_cnt=1.

Source files
------------

// File: rtl/triangle_dispatcher_pkg.sv
// Shared types for the triangle dispatcher: triangle record, host word map, FSM states.
package triangle_pkg;

    typedef struct packed {
        logic [15:0] v1x;
        logic [15:0] v1y;
        logic [15:0] v1z;
        logic [15:0] v2x;
        logic [15:0] v2y;
        logic [15:0] v2z;
        logic [15:0] v3x;
        logic [15:0] v3y;
        logic [15:0] v3z;
        logic [15:0] color;
    } tri_t;

    localparam logic [3:0] W_V1X   = 4'd0;
    localparam logic [3:0] W_V1Y   = 4'd1;
    localparam logic [3:0] W_V1Z   = 4'd2;
    localparam logic [3:0] W_V2X   = 4'd3;
    localparam logic [3:0] W_V2Y   = 4'd4;
    localparam logic [3:0] W_V2Z   = 4'd5;
    localparam logic [3:0] W_V3X   = 4'd6;
    localparam logic [3:0] W_V3Y   = 4'd7;
    localparam logic [3:0] W_V3Z   = 4'd8;
    localparam logic [3:0] W_COLOR = 4'd9;

    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

    // A triangle whose three vertices share one scanline covers no area.
    function automatic logic is_degenerate(input tri_t t);
        return (t.v1y == t.v2y) && (t.v2y == t.v3y);
    endfunction

endpackage

// File: rtl/triangle_dispatcher_if.sv
// Vertex/colour bus and start/done handshake between the dispatcher and the shader.
interface triangle_dispatcher_if;

    logic [15:0] v1x;
    logic [15:0] v1y;
    logic [15:0] v1z;
    logic [15:0] v2x;
    logic [15:0] v2y;
    logic [15:0] v2z;
    logic [15:0] v3x;
    logic [15:0] v3y;
    logic [15:0] v3z;
    logic [15:0] pixel_color;
    logic        sh_start;
    logic        sh_done;

    modport master (
        output v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z, pixel_color, sh_start,
        input  sh_done
    );

    modport slave (
        input  v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z, pixel_color, sh_start,
        output sh_done
    );

endinterface

// File: rtl/triangle_dispatcher_fifo.sv
// tri_fifo: DEPTH x tri_t synchronous FIFO with registered full/empty, async active-low reset.
module tri_fifo
    import triangle_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  logic i_pop,
    input  tri_t i_data,
    output tri_t o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    tri_t         r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         r_full;
    logic         r_empty;
    logic         w_do_push;
    logic         w_do_pop;
    logic [AW:0]  w_wr_next;
    logic [AW:0]  w_rd_next;

    // A push into a full FIFO is dropped even if a pop frees a slot in the same cycle.
    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop && !r_empty;
    assign w_wr_next = r_wr_ptr + {{AW{1'b0}}, w_do_push};
    assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_do_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_empty  <= (w_wr_next == w_rd_next);
            r_full   <= (w_wr_next[AW] != w_rd_next[AW]) &&
                        (w_wr_next[AW-1:0] == w_rd_next[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/triangle_dispatcher.sv
// Host-staged triangle queue feeding the shader start/done handshake.
// Optional DEGENERATE_CULL_EN: drop zero-height triangles at pop time and count them.
module triangle_dispatcher
    import triangle_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [15:0]       wr_data,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic              overflow,
    output logic [CNT_W-1:0]  tri_done_cnt,
`ifdef DEGENERATE_CULL_EN
    output logic [CNT_W-1:0]  culled_cnt,
`endif
    triangle_dispatcher_if.master sh
);

    logic [8:0][15:0] r_stage;
    state_t           r_state;
    state_t           w_state_next;
    tri_t             r_tri;
    logic             r_overflow;
    logic [CNT_W-1:0] r_done_cnt;
    tri_t             w_push_tri;
    tri_t             w_head;
    logic             w_commit;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_load;
    logic             w_done;
`ifdef DEGENERATE_CULL_EN
    logic             w_cull;
    logic [CNT_W-1:0] r_culled_cnt;
`endif

    assign w_commit = wr_en && (wr_addr == W_COLOR);

    assign w_push_tri = '{
        v1x:   r_stage[W_V1X],
        v1y:   r_stage[W_V1Y],
        v1z:   r_stage[W_V1Z],
        v2x:   r_stage[W_V2X],
        v2y:   r_stage[W_V2Y],
        v2z:   r_stage[W_V2Z],
        v3x:   r_stage[W_V3X],
        v3y:   r_stage[W_V3Y],
        v3z:   r_stage[W_V3Z],
        color: wr_data
    };

    // Staging is deliberately kept after a commit so the host can rewrite only changed words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stage <= '0;
        end else if (wr_en && (wr_addr <= W_V3Z)) begin
            r_stage[wr_addr] <= wr_data;
        end
    end

    tri_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_commit),
        .i_pop   (w_pop),
        .i_data  (w_push_tri),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
`ifdef DEGENERATE_CULL_EN
        w_cull       = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
`ifdef DEGENERATE_CULL_EN
                    if (is_degenerate(w_head)) begin
                        w_cull = 1'b1;
                    end else begin
                        w_load       = 1'b1;
                        w_state_next = LOAD;
                    end
`else
                    w_load       = 1'b1;
                    w_state_next = LOAD;
`endif
                end
            end
            LOAD:    w_state_next = START;
            START:   w_state_next = WAIT;
            WAIT: begin
                if (sh.sh_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_done = (r_state == WAIT) && sh.sh_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tri      <= '0;
            r_overflow <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            if (w_load) begin
                r_tri <= w_head;
            end
            if (w_commit && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_done) begin
                r_done_cnt <= r_done_cnt + 1'b1;
            end
        end
    end

`ifdef DEGENERATE_CULL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_culled_cnt <= '0;
        end else if (w_cull) begin
            r_culled_cnt <= r_culled_cnt + 1'b1;
        end
    end

    assign culled_cnt = r_culled_cnt;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign busy         = (r_state != IDLE);
    assign overflow     = r_overflow;
    assign tri_done_cnt = r_done_cnt;

    assign sh.v1x         = r_tri.v1x;
    assign sh.v1y         = r_tri.v1y;
    assign sh.v1z         = r_tri.v1z;
    assign sh.v2x         = r_tri.v2x;
    assign sh.v2y         = r_tri.v2y;
    assign sh.v2z         = r_tri.v2z;
    assign sh.v3x         = r_tri.v3x;
    assign sh.v3y         = r_tri.v3y;
    assign sh.v3z         = r_tri.v3z;
    assign sh.pixel_color = r_tri.color;
    assign sh.sh_start    = (r_state == START);

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Directed bench for triangle_dispatcher: table-driven burst plus hand-written handshake sequences.
module tb_triangle_dispatcher;
    import triangle_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;

    typedef struct {
        tri_t tin;
        logic exp_full;
        logic exp_ovf;
        logic exp_disp;
    } vec_t;

    logic             clk     = 1'b0;
    logic             reset   = 1'b1;
    logic             wr_en   = 1'b0;
    logic [3:0]       wr_addr = '0;
    logic [15:0]      wr_data = '0;
    logic             full;
    logic             empty;
    logic             busy;
    logic             overflow;
    logic [CNT_W-1:0] tri_done_cnt;
`ifdef DEGENERATE_CULL_EN
    logic [CNT_W-1:0] culled_cnt;
`endif

    triangle_dispatcher_if u_if ();

    triangle_dispatcher #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .busy         (busy),
        .overflow     (overflow),
        .tri_done_cnt (tri_done_cnt),
`ifdef DEGENERATE_CULL_EN
        .culled_cnt   (culled_cnt),
`endif
        .sh           (u_if)
    );

    always #10 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_cnt  = 0;
    vec_t tab [5];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic tri_t out_tri();
        return '{v1x: u_if.v1x, v1y: u_if.v1y, v1z: u_if.v1z,
                 v2x: u_if.v2x, v2y: u_if.v2y, v2z: u_if.v2z,
                 v3x: u_if.v3x, v3y: u_if.v3y, v3z: u_if.v3z,
                 color: u_if.pixel_color};
    endfunction

    function automatic tri_t mk(input logic [15:0] b);
        return '{v1x: b,         v1y: b + 16'd1, v1z: b + 16'd2,
                 v2x: b + 16'd3, v2y: b + 16'd4, v2z: b + 16'd5,
                 v3x: b + 16'd6, v3y: b + 16'd7, v3z: b + 16'd8,
                 color: b + 16'd9};
    endfunction

    // All tasks start and end on a falling clock edge.
    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic stage(input tri_t t);
        wr(4'd0, t.v1x); wr(4'd1, t.v1y); wr(4'd2, t.v1z);
        wr(4'd3, t.v2x); wr(4'd4, t.v2y); wr(4'd5, t.v2z);
        wr(4'd6, t.v3x); wr(4'd7, t.v3y); wr(4'd8, t.v3z);
    endtask

    task automatic commit(input tri_t t);
        stage(t);
        wr(4'd9, t.color);
    endtask

    task automatic wait_start(input string name);
        int k;
        k = 0;
        while (u_if.sh_start !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (u_if.sh_start !== 1'b1) begin
            n_errors++;
            $display("FAIL %s: sh_start=%b after %0d cycles, required 1", name, u_if.sh_start, k);
        end
    endtask

    task automatic finish_tri();
        if (u_if.sh_start === 1'b1) @(negedge clk);
        u_if.sh_done = 1'b1;
        @(negedge clk);
        u_if.sh_done = 1'b0;
        exp_cnt++;
    endtask

    // Done in WAIT followed immediately by a commit, so the commit lands on the IDLE pop edge.
    task automatic done_then_commit(input logic [15:0] color);
        u_if.sh_done = 1'b1;
        @(negedge clk);
        exp_cnt++;
        u_if.sh_done = 1'b0;
        wr(4'd9, color);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tri_t t_a;
        tri_t t;

        t_a = '{v1x: 16'd10,  v1y: 16'd10, v1z: 16'd5,
                v2x: 16'd100, v2y: 16'd20, v2z: 16'd5,
                v3x: 16'd50,  v3y: 16'd90, v3z: 16'd5,
                color: 16'd3};
        tab[0] = '{tin: mk(16'h2000), exp_full: 1'b0, exp_ovf: 1'b0, exp_disp: 1'b1};
        tab[1] = '{tin: mk(16'h2100), exp_full: 1'b0, exp_ovf: 1'b0, exp_disp: 1'b1};
        tab[2] = '{tin: mk(16'h2200), exp_full: 1'b0, exp_ovf: 1'b0, exp_disp: 1'b1};
        tab[3] = '{tin: mk(16'h2300), exp_full: 1'b1, exp_ovf: 1'b0, exp_disp: 1'b1};
        tab[4] = '{tin: mk(16'h2400), exp_full: 1'b1, exp_ovf: 1'b1, exp_disp: 1'b0};

        u_if.sh_done = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_cnt", tri_done_cnt, '0);
        chk("rst_start", u_if.sh_start, 1'b0);
        chk("rst_tri", out_tri(), '0);

        // Single triangle: exact latency and a 200-cycle shader.
        commit(t_a);
        chk("single_empty_after_commit", empty, 1'b0);
        chk("single_busy_after_commit", busy, 1'b0);
        @(negedge clk);
        chk("single_load_busy", busy, 1'b1);
        chk("single_load_start", u_if.sh_start, 1'b0);
        chk("single_load_tri", out_tri(), t_a);
        chk("single_load_empty", empty, 1'b1);
        @(negedge clk);
        chk("single_start_high", u_if.sh_start, 1'b1);
        @(negedge clk);
        chk("single_start_one_cycle", u_if.sh_start, 1'b0);
        repeat (196) @(negedge clk);
        chk("single_wait_tri", out_tri(), t_a);
        chk("single_wait_busy", busy, 1'b1);
        finish_tri();
        chk("single_cnt", tri_done_cnt, CNT_W'(exp_cnt));
        chk("single_busy_end", busy, 1'b0);
        chk("single_empty_end", empty, 1'b1);

        // Colour-only commit reuses the previous staged coordinates.
        wr(4'd9, 16'h00F0);
        wait_start("recommit_start");
        t = t_a;
        t.color = 16'h00F0;
        chk("recommit_tri", out_tri(), t);
        finish_tri();

        // Staging writes during WAIT must not disturb the outputs.
        commit(mk(16'h0100));
        wait_start("stable_start");
        stage(mk(16'hDE00));
        chk("stable_tri", out_tri(), mk(16'h0100));
        chk("stable_busy", busy, 1'b1);
        finish_tri();
        chk("stable_cnt", tri_done_cnt, CNT_W'(exp_cnt));
        u_if.sh_done = 1'b1;
        @(negedge clk);
        u_if.sh_done = 1'b0;
        @(negedge clk);
        chk("spurious_done_cnt", tri_done_cnt, CNT_W'(exp_cnt));
        chk("spurious_done_busy", busy, 1'b0);

        // Burst while the shader is held on a blocker triangle.
        commit(mk(16'h0200));
        wait_start("burst_blocker_start");
        for (int i = 0; i < 5; i++) begin
            commit(tab[i].tin);
            chk($sformatf("burst_full_%0d", i), full, tab[i].exp_full);
            chk($sformatf("burst_ovf_%0d", i), overflow, tab[i].exp_ovf);
        end
        finish_tri();
        for (int i = 0; i < 5; i++) begin
            if (tab[i].exp_disp) begin
                wait_start($sformatf("burst_start_%0d", i));
                chk($sformatf("burst_tri_%0d", i), out_tri(), tab[i].tin);
                finish_tri();
            end
        end
        chk("burst_empty", empty, 1'b1);
        chk("burst_busy", busy, 1'b0);
        chk("burst_cnt", tri_done_cnt, CNT_W'(exp_cnt));
        chk("burst_ovf_sticky", overflow, 1'b1);

        // Push and pop on the same edge with two entries queued.
        commit(mk(16'h0300));
        wait_start("pp2_blocker_start");
        commit(mk(16'h0400));
        commit(mk(16'h0500));
        stage(mk(16'h0600));
        t = mk(16'h0600);
        done_then_commit(t.color);
        chk("pp2_empty", empty, 1'b0);
        chk("pp2_full", full, 1'b0);
        chk("pp2_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            wait_start($sformatf("pp2_start_%0d", i));
            chk($sformatf("pp2_tri_%0d", i), out_tri(), mk(16'h0400 + 16'(i) * 16'h0100));
            finish_tri();
        end
        chk("pp2_drained", empty, 1'b1);
        chk("pp2_cnt", tri_done_cnt, CNT_W'(exp_cnt));

        // Reset in WAIT with three triangles queued.
        commit(mk(16'h0700));
        wait_start("rstw_blocker_start");
        commit(mk(16'h0800));
        commit(mk(16'h0900));
        commit(mk(16'h0A00));
        reset = 1'b0;
        #1;
        exp_cnt = 0;
        chk("rstw_tri", out_tri(), '0);
        chk("rstw_start", u_if.sh_start, 1'b0);
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_empty", empty, 1'b1);
        chk("rstw_overflow", overflow, 1'b0);
        chk("rstw_cnt", tri_done_cnt, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        commit(mk(16'h0B00));
        wait_start("rstw_new_start");
        chk("rstw_new_tri", out_tri(), mk(16'h0B00));
        finish_tri();
        repeat (4) @(negedge clk);
        chk("rstw_new_cnt", tri_done_cnt, CNT_W'(exp_cnt));
        chk("rstw_no_leftover", busy, 1'b0);

`ifdef DEGENERATE_CULL_EN
        commit(mk(16'h0C00));
        wait_start("cull_blocker_start");
        t = mk(16'h0D00);
        t.v1y = 16'd40;
        t.v2y = 16'd40;
        t.v3y = 16'd40;
        commit(t);
        commit(mk(16'h0E00));
        finish_tri();
        wait_start("cull_valid_start");
        chk("cull_valid_tri", out_tri(), mk(16'h0E00));
        finish_tri();
        repeat (4) @(negedge clk);
        chk("cull_culled_cnt", culled_cnt, CNT_W'(1));
        chk("cull_done_cnt", tri_done_cnt, CNT_W'(exp_cnt));
        chk("cull_busy", busy, 1'b0);
`endif

        // Push and pop on the same edge while full: push is dropped.
        commit(mk(16'h1000));
        wait_start("ppf_blocker_start");
        for (int i = 1; i <= 4; i++) begin
            commit(mk(16'h1000 + 16'(i) * 16'h0100));
        end
        chk("ppf_full_before", full, 1'b1);
        chk("ppf_ovf_before", overflow, 1'b0);
        stage(mk(16'h1500));
        t = mk(16'h1500);
        done_then_commit(t.color);
        chk("ppf_ovf", overflow, 1'b1);
        chk("ppf_full_after", full, 1'b0);
        chk("ppf_empty_after", empty, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            wait_start($sformatf("ppf_start_%0d", i));
            chk($sformatf("ppf_tri_%0d", i), out_tri(), mk(16'h1000 + 16'(i) * 16'h0100));
            finish_tri();
        end
        repeat (5) @(negedge clk);
        chk("ppf_dropped_not_dispatched", busy, 1'b0);
        chk("ppf_empty_end", empty, 1'b1);
        chk("ppf_cnt", tri_done_cnt, CNT_W'(exp_cnt));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
